// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// Contents:
//   adderState_t - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   cntWidth()   - bit-counter width for a given operand width, $clog2(width+1)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } adderState_t;

  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder.
// Ports (master = requester, slave = adder):
//   start, sub, cin, a[WIDTH], b[WIDTH] : request side, driven by master
//   busy, done, sum[WIDTH], cout, ovf   : status/result side, driven by slave
interface serial_adder_if #(parameter int WIDTH = 8);

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder built from two half-adder stages and an OR.
// Ports:
//   a, b, ci : input bits and carry-in
//   s, co    : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic ha1Sum;
  logic ha1Carry;
  logic ha2Carry;

  // First half adder combines the operands, second folds in the carry.
  assign ha1Sum   = a ^ b;
  assign ha1Carry = a & b;
  assign s        = ha1Sum ^ ci;
  assign ha2Carry = ha1Sum & ci;
  assign co       = ha1Carry | ha2Carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// the operands LSB-first, one bit per clock.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, takes priority over start
//   bus  : serial_adder_if slave - start/sub/cin/a/b in, busy/done/sum/cout/ovf out
// A start is accepted whenever the adder is not busy (IDLE or DONE), so
// back-to-back requests in the done cycle are taken without a gap.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = cntWidth(WIDTH);

  adderState_t      state;
  adderState_t      nextState;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] resReg;
  logic [WIDTH-1:0] sumReg;
  logic             carry;
  logic             coutReg;
  logic             ovfReg;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             lastBit;
  logic             faSum;
  logic             faCarry;

  assign accept  = bus.start && (state != ST_RUN);
  assign lastBit = (cnt == CNT_W'(WIDTH - 1));

  full_adder uFa (
    .a  (aReg[0]),
    .b  (bReg[0]),
    .ci (carry),
    .s  (faSum),
    .co (faCarry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, DONE lasts one cycle
  // and can hand straight back to RUN when a new start arrives.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (accept)  nextState = ST_RUN;
      ST_RUN:  if (lastBit) nextState = ST_DONE;
      ST_DONE: nextState = accept ? ST_RUN : ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Datapath: operands are captured on the accepting edge (B inverted and
  // carry forced to 1 for subtraction), then one bit is consumed per edge.
  // On the last bit the carry flop still holds the carry into the MSB, which
  // is what the overflow test needs. Visible results only move at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      aReg    <= '0;
      bReg    <= '0;
      resReg  <= '0;
      sumReg  <= '0;
      carry   <= 1'b0;
      coutReg <= 1'b0;
      ovfReg  <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      aReg   <= bus.a;
      bReg   <= bus.sub ? ~bus.b : bus.b;
      carry  <= bus.sub ? 1'b1 : bus.cin;
      resReg <= '0;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      resReg <= {faSum, resReg[WIDTH-1:1]};
      aReg   <= aReg >> 1;
      bReg   <= bReg >> 1;
      carry  <= faCarry;
      cnt    <= cnt + CNT_W'(1);
      if (lastBit) begin
        sumReg  <= {faSum, resReg[WIDTH-1:1]};
        coutReg <= faCarry;
        ovfReg  <= carry ^ faCarry;
      end
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.sum  = sumReg;
  assign bus.cout = coutReg;
  assign bus.ovf  = ovfReg;

endmodule
